// File: rtl/alu_if.sv
// ---------------------------------------------------------------------------
// alu_if : operand/result bundle for the registered ALU.
//
// Signals
//    in_valid  caller -> alu  operands/opcode valid, sampled on rising clk
//    A, B      caller -> alu  operands (WIDTH bits)
//    Opcode    caller -> alu  operation select (3 bits)
//    Result    alu -> caller  registered result (WIDTH bits)
//    CarryOut  alu -> caller  registered carry/borrow/shift-out flag
//    Zero      alu -> caller  registered, 1 when Result == 0
//    Overflow  alu -> caller  registered signed overflow (add/sub only)
//    out_valid alu -> caller  registered, Result/flags updated this cycle
//
// Handshake: there is no ready. Every cycle with in_valid=1 at a rising
// edge is accepted, and the matching result appears after that edge with
// out_valid=1 for exactly one cycle. With in_valid=0 the outputs hold and
// out_valid=0.
//
// Modports
//    master  the caller (drives operands, observes results)
//    slave   the ALU
// ---------------------------------------------------------------------------
interface alu_if #(
   parameter int WIDTH = 4
);
   logic             in_valid;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [2:0]       Opcode;
   logic [WIDTH-1:0] Result;
   logic             CarryOut;
   logic             Zero;
   logic             Overflow;
   logic             out_valid;

   modport master (
      output in_valid, A, B, Opcode,
      input  Result, CarryOut, Zero, Overflow, out_valid
   );

   modport slave (
      input  in_valid, A, B, Opcode,
      output Result, CarryOut, Zero, Overflow, out_valid
   );
endinterface

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu : registered WIDTH-bit arithmetic/logic unit, eight operations.
//
// Ports
//    clk   rising-edge clock
//    rst   asynchronous active-high reset, clears every output
//    bus   alu_if.slave : in_valid/A/B/Opcode in, Result/CarryOut/Zero/
//          Overflow/out_valid out, all outputs registered (1-cycle latency)
//
// Opcodes
//    000 ADD  001 SUB  010 AND  011 OR  100 XOR  101 NOT(A)
//    110 SHL(A) by one, carry = shifted-out MSB
//    111 SHR(A) logical by one, carry = shifted-out LSB
// ---------------------------------------------------------------------------
module alu #(
   parameter int WIDTH = 4
) (
   input logic  clk,
   input logic  rst,
   alu_if.slave bus
);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_NOT = 3'b101;
   localparam logic [2:0] OP_SHL = 3'b110;
   localparam logic [2:0] OP_SHR = 3'b111;

   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_diff;
   logic [WIDTH-1:0] w_result;
   logic             w_carry;
   logic             w_overflow;

   logic [WIDTH-1:0] r_result;
   logic             r_carry;
   logic             r_zero;
   logic             r_overflow;
   logic             r_out_valid;

   // Zero-extended so bit WIDTH is the carry (add) or the borrow (sub):
   // the subtraction wraps negative exactly when A < B unsigned.
   assign w_sum  = {1'b0, bus.A} + {1'b0, bus.B};
   assign w_diff = {1'b0, bus.A} - {1'b0, bus.B};

   always_comb begin
      w_result   = '0;
      w_carry    = 1'b0;
      w_overflow = 1'b0;
      case (bus.Opcode)
         OP_ADD: begin
            w_result   = w_sum[WIDTH-1:0];
            w_carry    = w_sum[WIDTH];
            // Same-sign operands producing a result of the other sign.
            w_overflow = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) &&
                         (w_sum[WIDTH-1] != bus.A[WIDTH-1]);
         end
         OP_SUB: begin
            w_result   = w_diff[WIDTH-1:0];
            w_carry    = w_diff[WIDTH];
            // Opposite-sign operands with the result sign flipped from A.
            w_overflow = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) &&
                         (w_diff[WIDTH-1] != bus.A[WIDTH-1]);
         end
         OP_AND: w_result = bus.A & bus.B;
         OP_OR:  w_result = bus.A | bus.B;
         OP_XOR: w_result = bus.A ^ bus.B;
         OP_NOT: w_result = ~bus.A;
         OP_SHL: begin
            w_result = {bus.A[WIDTH-2:0], 1'b0};
            w_carry  = bus.A[WIDTH-1];
         end
         OP_SHR: begin
            w_result = {1'b0, bus.A[WIDTH-1:1]};
            w_carry  = bus.A[0];
         end
         default: begin
            w_result   = '0;
            w_carry    = 1'b0;
            w_overflow = 1'b0;
         end
      endcase
   end

   // Result and flags only load on an accepted operation; out_valid is a
   // one-cycle pulse per accepted operation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_result    <= '0;
         r_carry     <= 1'b0;
         r_zero      <= 1'b0;
         r_overflow  <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= bus.in_valid;
         if (bus.in_valid) begin
            r_result   <= w_result;
            r_carry    <= w_carry;
            r_zero     <= (w_result == '0);
            r_overflow <= w_overflow;
         end
      end
   end

   assign bus.Result    = r_result;
   assign bus.CarryOut  = r_carry;
   assign bus.Zero      = r_zero;
   assign bus.Overflow  = r_overflow;
   assign bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// tb_alu : directed self-checking bench for alu (WIDTH = 4).
// ---------------------------------------------------------------------------
module tb_alu;

   localparam int WIDTH = 4;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   alu_if #(.WIDTH(WIDTH)) bus ();

   alu #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checking ----------------
   task automatic check_val(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [WIDTH-1:0] er,
                            input logic ec, input logic ez, input logic ev,
                            input logic eval);
      check_val({tag, ".result"},    32'(bus.Result),    32'(er));
      check_val({tag, ".carry"},     32'(bus.CarryOut),  32'(ec));
      check_val({tag, ".zero"},      32'(bus.Zero),      32'(ez));
      check_val({tag, ".overflow"},  32'(bus.Overflow),  32'(ev));
      check_val({tag, ".out_valid"}, 32'(bus.out_valid), 32'(eval));
   endtask

   // ---------------- driver ----------------
   // Called 1 time unit after a rising edge; drives an operation, waits for
   // the capturing edge and checks the registered outputs. Successive calls
   // keep in_valid high, so they form a back-to-back stream.
   task automatic run_op(input string tag, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [2:0] op,
                         input logic [WIDTH-1:0] er, input logic ec,
                         input logic ez, input logic ev);
      bus.in_valid = 1'b1;
      bus.A        = a;
      bus.B        = b;
      bus.Opcode   = op;
      @(posedge clk);
      #1;
      check_all(tag, er, ec, ez, ev, 1'b1);
   endtask

   task automatic idle_cycle(input string tag, input logic [WIDTH-1:0] er,
                             input logic ec, input logic ez, input logic ev);
      bus.in_valid = 1'b0;
      bus.A        = WIDTH'($urandom_range(0, 15));
      bus.B        = WIDTH'($urandom_range(0, 15));
      bus.Opcode   = 3'($urandom_range(0, 7));
      @(posedge clk);
      #1;
      check_all(tag, er, ec, ez, ev, 1'b0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      n_checks     = 0;
      n_errors     = 0;
      rst          = 1'b1;
      bus.in_valid = 1'b1;
      bus.A        = 4'b1111;
      bus.B        = 4'b1111;
      bus.Opcode   = 3'b000;

      // Reset holds everything at zero even with in_valid high.
      repeat (2) @(posedge clk);
      #1;
      check_all("reset", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
      bus.in_valid = 1'b0;
      rst          = 1'b0;

      idle_cycle("idle0", 4'b0000, 1'b0, 1'b0, 1'b0);
      idle_cycle("idle1", 4'b0000, 1'b0, 1'b0, 1'b0);

      // Back-to-back stream of directed vectors.
      //            tag       A        B        op      Result   C     Z     V
      run_op("add_3_1",  4'b0011, 4'b0001, 3'b000, 4'b0100, 1'b0, 1'b0, 1'b0);
      run_op("add_f_1",  4'b1111, 4'b0001, 3'b000, 4'b0000, 1'b1, 1'b1, 1'b0);
      run_op("sub_5_3",  4'b0101, 4'b0011, 3'b001, 4'b0010, 1'b0, 1'b0, 1'b0);
      run_op("sub_1_3",  4'b0001, 4'b0011, 3'b001, 4'b1110, 1'b1, 1'b0, 1'b0);
      run_op("add_7_1",  4'b0111, 4'b0001, 3'b000, 4'b1000, 1'b0, 1'b0, 1'b1);
      run_op("add_8_8",  4'b1000, 4'b1000, 3'b000, 4'b0000, 1'b1, 1'b1, 1'b1);
      run_op("sub_8_1",  4'b1000, 4'b0001, 3'b001, 4'b0111, 1'b0, 1'b0, 1'b1);
      run_op("sub_5_5",  4'b0101, 4'b0101, 3'b001, 4'b0000, 1'b0, 1'b1, 1'b0);
      run_op("and",      4'b1100, 4'b1010, 3'b010, 4'b1000, 1'b0, 1'b0, 1'b0);
      run_op("or",       4'b1100, 4'b1010, 3'b011, 4'b1110, 1'b0, 1'b0, 1'b0);
      run_op("xor",      4'b1100, 4'b1010, 3'b100, 4'b0110, 1'b0, 1'b0, 1'b0);
      run_op("not",      4'b1100, 4'b1010, 3'b101, 4'b0011, 1'b0, 1'b0, 1'b0);
      run_op("shl_c",    4'b1100, 4'b0000, 3'b110, 4'b1000, 1'b1, 1'b0, 1'b0);
      run_op("shr_c",    4'b1100, 4'b1111, 3'b111, 4'b0110, 1'b0, 1'b0, 1'b0);
      run_op("shr_1",    4'b0001, 4'b0000, 3'b111, 4'b0000, 1'b1, 1'b1, 1'b0);
      run_op("shl_5",    4'b0101, 4'b1111, 3'b110, 4'b1010, 1'b0, 1'b0, 1'b0);

      // Drop in_valid with changing inputs: outputs freeze at last result.
      idle_cycle("hold0", 4'b1010, 1'b0, 1'b0, 1'b0);
      idle_cycle("hold1", 4'b1010, 1'b0, 1'b0, 1'b0);
      idle_cycle("hold2", 4'b1010, 1'b0, 1'b0, 1'b0);

      // Asynchronous reset between edges while out_valid is high.
      run_op("pre_rst",  4'b0111, 4'b0001, 3'b000, 4'b1000, 1'b0, 1'b0, 1'b1);
      bus.in_valid = 1'b0;
      #3;
      rst = 1'b1;
      #1;
      check_all("async_rst", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Normal operation resumes after reset.
      run_op("post_rst", 4'b0110, 4'b0011, 3'b001, 4'b0011, 1'b0, 1'b0, 1'b0);
      bus.in_valid = 1'b0;
      @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
